// File: rtl/rx_frame_buffer.sv
// Two-bank frame store between the UDP receive parser and the inference accelerator.
// Latency: a commit on edge T gives OUT_VALID with byte 0 after edge T+2; 1 byte/cycle while OUT_READY is held high.
// Backpressure: OUT_READY low holds OUT_DATA/OUT_LAST/sideband; a commit with no free bank is dropped and counted.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   RX_DATA/RX_ADDR/RX_EN per-byte writes into the current write bank
//   FRAME_READY + SRC_*   commit pulse with the sender identity for that frame
//   OUT_DATA/VALID/READY/LAST, OUT_SRC_*  byte stream plus per-frame sideband
//   DROP_COUNT            saturating count of frames dropped for lack of a free bank
//   BANKS_BUSY            debug: neither bank is FREE
module rx_frame_buffer #(
    parameter int USER_DATA_BYTES = 785,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [7:0]            RX_DATA,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic                  RX_EN,
    input  logic                  FRAME_READY,
    input  logic [31:0]           SRC_IP_ADDRESS,
    input  logic [47:0]           SRC_MAC_ADDRESS,
    input  logic [15:0]           SRC_UDP_PORT,
    output logic [7:0]            OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  OUT_LAST,
    output logic [31:0]           OUT_SRC_IP,
    output logic [47:0]           OUT_SRC_MAC,
    output logic [15:0]           OUT_SRC_UDP,
    output logic [15:0]           DROP_COUNT,
    output logic                  BANKS_BUSY
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(USER_DATA_BYTES - 1);

    typedef enum logic [1:0] {BANK_FREE, BANK_FULL, BANK_READING} bank_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_t;

    bank_state_t           bank_q [2];
    bank_state_t           bank_d [2];
    logic                  wr_sel_q, wr_sel_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [31:0]           sb_ip_q  [2];
    logic [47:0]           sb_mac_q [2];
    logic [15:0]           sb_udp_q [2];

    rd_state_t             rd_state_q;
    logic                  rd_sel_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;      // address of the byte currently held in ram_rd_q
    logic [7:0]            ram_rd_q;       // prefetched next byte
    logic [7:0]            out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [31:0]           out_ip_q;
    logic [47:0]           out_mac_q;
    logic [15:0]           out_udp_q;

    logic [7:0]            mem_a [USER_DATA_BYTES];
    logic [7:0]            mem_b [USER_DATA_BYTES];

    logic                  rd_hs, rd_done, rd_start, start_sel, rd_adv;
    logic                  other_free, commit, drop, wr_ok;
    logic                  ram_rd_en, ram_rd_bank;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;

    always_comb begin
        rd_hs     = out_valid_q && OUT_READY;
        rd_done   = (rd_state_q == RD_STREAM) && rd_hs && out_last_q;
        rd_start  = (rd_state_q == RD_IDLE) &&
                    ((bank_q[0] == BANK_FULL) || (bank_q[1] == BANK_FULL));
        start_sel = (bank_q[0] == BANK_FULL) ? 1'b0 : 1'b1;
        // Load the prefetched byte into the output register: on the prime cycle, or on
        // each handshake that is not the final one.
        rd_adv    = (rd_state_q == RD_PRIME) ||
                    ((rd_state_q == RD_STREAM) && rd_hs && !out_last_q);

        // A bank released by the final handshake this very cycle counts as free.
        other_free = (bank_q[~wr_sel_q] == BANK_FREE) || (rd_done && (rd_sel_q != wr_sel_q));
        commit     = FRAME_READY && other_free;
        drop       = FRAME_READY && !other_free;

        ram_rd_en   = rd_start || (rd_adv && (rd_addr_q != LAST_ADDR));
        ram_rd_addr = rd_start ? '0 : rd_addr_q + ADDR_WIDTH'(1);
        ram_rd_bank = rd_start ? start_sel : rd_sel_q;

        wr_ok = RX_EN && (RX_ADDR <= LAST_ADDR);
    end

    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (rd_done)  bank_d[rd_sel_q]  = BANK_FREE;
        if (rd_start) bank_d[start_sel] = BANK_READING;
        if (commit)   bank_d[wr_sel_q]  = BANK_FULL;
        wr_sel_d   = wr_sel_q ^ commit;
        drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    // Bank bookkeeping and per-bank sideband capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bank_q[0]   <= BANK_FREE;
            bank_q[1]   <= BANK_FREE;
            wr_sel_q    <= 1'b0;
            drop_cnt_q  <= '0;
            sb_ip_q[0]  <= '0;
            sb_ip_q[1]  <= '0;
            sb_mac_q[0] <= '0;
            sb_mac_q[1] <= '0;
            sb_udp_q[0] <= '0;
            sb_udp_q[1] <= '0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            wr_sel_q   <= wr_sel_d;
            drop_cnt_q <= drop_cnt_d;
            if (commit) begin
                sb_ip_q[wr_sel_q]  <= SRC_IP_ADDRESS;
                sb_mac_q[wr_sel_q] <= SRC_MAC_ADDRESS;
                sb_udp_q[wr_sel_q] <= SRC_UDP_PORT;
            end
        end
    end

    // Frame RAMs: one write port from the parser, one synchronous read port for the reader.
    // Contents survive reset on purpose.
    always_ff @(posedge ACLK) begin
        if (wr_ok && !wr_sel_q) mem_a[RX_ADDR] <= RX_DATA;
        if (wr_ok &&  wr_sel_q) mem_b[RX_ADDR] <= RX_DATA;
        if (ram_rd_en) ram_rd_q <= ram_rd_bank ? mem_b[ram_rd_addr] : mem_a[ram_rd_addr];
    end

    // Reader: IDLE -> PRIME (byte 0 read) -> STREAM (output register + one-byte prefetch).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q  <= RD_IDLE;
            rd_sel_q    <= 1'b0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ip_q    <= '0;
            out_mac_q   <= '0;
            out_udp_q   <= '0;
        end else begin
            if (ram_rd_en) rd_addr_q <= ram_rd_addr;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_start) begin
                        rd_state_q <= RD_PRIME;
                        rd_sel_q   <= start_sel;
                        out_ip_q   <= sb_ip_q[start_sel];
                        out_mac_q  <= sb_mac_q[start_sel];
                        out_udp_q  <= sb_udp_q[start_sel];
                    end
                end
                RD_PRIME: begin
                    rd_state_q  <= RD_STREAM;
                    out_valid_q <= 1'b1;
                    out_data_q  <= ram_rd_q;
                    out_last_q  <= (rd_addr_q == LAST_ADDR);
                end
                RD_STREAM: begin
                    if (rd_hs) begin
                        if (out_last_q) begin
                            rd_state_q  <= RD_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_data_q <= ram_rd_q;
                            out_last_q <= (rd_addr_q == LAST_ADDR);
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign OUT_DATA    = out_data_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_LAST    = out_last_q;
    assign OUT_SRC_IP  = out_ip_q;
    assign OUT_SRC_MAC = out_mac_q;
    assign OUT_SRC_UDP = out_udp_q;
    assign DROP_COUNT  = drop_cnt_q;
    assign BANKS_BUSY  = (bank_q[0] != BANK_FREE) && (bank_q[1] != BANK_FREE);

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: reset, single frame, overlap, drop, backpressure,
// same-cycle commit/release and reset mid-stream. Frame byte k of a frame with seed s is (k+s) mod 256.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at that same point.
module tb_rx_frame_buffer;

    localparam int N = 785;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  RX_DATA;
    logic [9:0]  RX_ADDR;
    logic        RX_EN;
    logic        FRAME_READY;
    logic [31:0] SRC_IP_ADDRESS;
    logic [47:0] SRC_MAC_ADDRESS;
    logic [15:0] SRC_UDP_PORT;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic [31:0] OUT_SRC_IP;
    logic [47:0] OUT_SRC_MAC;
    logic [15:0] OUT_SRC_UDP;
    logic [15:0] DROP_COUNT;
    logic        BANKS_BUSY;

    int checks   = 0;
    int failures = 0;
    int cyc_used;
    int wait_cnt;

    rx_frame_buffer #(.USER_DATA_BYTES(N), .ADDR_WIDTH(10)) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .RX_DATA        (RX_DATA),
        .RX_ADDR        (RX_ADDR),
        .RX_EN          (RX_EN),
        .FRAME_READY    (FRAME_READY),
        .SRC_IP_ADDRESS (SRC_IP_ADDRESS),
        .SRC_MAC_ADDRESS(SRC_MAC_ADDRESS),
        .SRC_UDP_PORT   (SRC_UDP_PORT),
        .OUT_DATA       (OUT_DATA),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .OUT_LAST       (OUT_LAST),
        .OUT_SRC_IP     (OUT_SRC_IP),
        .OUT_SRC_MAC    (OUT_SRC_MAC),
        .OUT_SRC_UDP    (OUT_SRC_UDP),
        .DROP_COUNT     (DROP_COUNT),
        .BANKS_BUSY     (BANKS_BUSY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_frame(input int seed);
        for (int k = 0; k < N; k++) begin
            RX_EN   = 1'b1;
            RX_ADDR = 10'(k);
            RX_DATA = 8'((k + seed) & 255);
            step();
        end
        RX_EN = 1'b0;
    endtask

    task automatic commit(input logic [31:0] ip, input logic [47:0] mac, input logic [15:0] port);
        FRAME_READY     = 1'b1;
        SRC_IP_ADDRESS  = ip;
        SRC_MAC_ADDRESS = mac;
        SRC_UDP_PORT    = port;
        step();
        FRAME_READY     = 1'b0;
        SRC_IP_ADDRESS  = '0;
        SRC_MAC_ADDRESS = '0;
        SRC_UDP_PORT    = '0;
    endtask

    // Accept up to 'limit' bytes; stall=1 asserts OUT_READY one cycle in three.
    task automatic receive_frame(input string name, input int seed, input logic [31:0] ip,
                                 input logic [47:0] mac, input logic [15:0] port,
                                 input bit stall, input int limit, output int cycles);
        int cnt = 0, cyc = 0, data_err = 0, last_err = 0, sb_err = 0, hold_err = 0;
        bit rdy, prev_stall = 1'b0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        while (cnt < limit && cyc < 5000) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            OUT_READY = rdy;
            if (prev_stall && (OUT_VALID !== 1'b1 || OUT_DATA !== pd || OUT_LAST !== pl))
                hold_err++;
            if (OUT_VALID === 1'b1) begin
                if (OUT_SRC_IP !== ip || OUT_SRC_MAC !== mac || OUT_SRC_UDP !== port) sb_err++;
                if (rdy) begin
                    if (OUT_DATA !== 8'((cnt + seed) & 255)) data_err++;
                    if (OUT_LAST !== (cnt == N - 1)) last_err++;
                    cnt++;
                end
            end
            prev_stall = (OUT_VALID === 1'b1) && !rdy;
            pd = OUT_DATA;
            pl = OUT_LAST;
            step();
            cyc++;
        end
        OUT_READY = 1'b1;
        cycles = cyc;
        chk({name, "/handshakes"}, 64'(cnt), 64'(limit));
        chk({name, "/data_errors"}, 64'(data_err), 64'd0);
        chk({name, "/last_errors"}, 64'(last_err), 64'd0);
        chk({name, "/sideband_errors"}, 64'(sb_err), 64'd0);
        if (stall) chk({name, "/stall_hold_errors"}, 64'(hold_err), 64'd0);
        if (limit == N) chk({name, "/valid_after_last"}, 64'(OUT_VALID), 64'd0);
    endtask

    initial begin
        ARESET = 1'b1; RX_DATA = '0; RX_ADDR = '0; RX_EN = 1'b0; FRAME_READY = 1'b0;
        SRC_IP_ADDRESS = '0; SRC_MAC_ADDRESS = '0; SRC_UDP_PORT = '0; OUT_READY = 1'b0;
        repeat (3) step();
        chk("reset/valid", 64'(OUT_VALID), 64'd0);
        chk("reset/last", 64'(OUT_LAST), 64'd0);
        chk("reset/data", 64'(OUT_DATA), 64'd0);
        chk("reset/ip", 64'(OUT_SRC_IP), 64'd0);
        chk("reset/mac", 64'(OUT_SRC_MAC), 64'd0);
        chk("reset/udp", 64'(OUT_SRC_UDP), 64'd0);
        chk("reset/drop", 64'(DROP_COUNT), 64'd0);
        chk("reset/busy", 64'(BANKS_BUSY), 64'd0);
        ARESET = 1'b0;
        step();

        // Single frame with commit-to-first-byte latency.
        OUT_READY = 1'b1;
        write_frame(0);
        commit(32'h0A000002, 48'h001122334455, 16'h1234);
        chk("single/valid_T", 64'(OUT_VALID), 64'd0);
        step();
        chk("single/valid_T1", 64'(OUT_VALID), 64'd0);
        step();
        chk("single/valid_T2", 64'(OUT_VALID), 64'd1);
        chk("single/first_byte", 64'(OUT_DATA), 64'd0);
        receive_frame("single", 0, 32'h0A000002, 48'h001122334455, 16'h1234, 1'b0, N, cyc_used);
        chk("single/cycles", 64'(cyc_used), 64'(N));

        // Overlap: write frame 2 while frame 1 streams, commit after frame 1 ends.
        write_frame(1);
        commit(32'hC0A80001, 48'hA1A2A3A4A5A6, 16'h1001);
        fork
            receive_frame("overlap_f1", 1, 32'hC0A80001, 48'hA1A2A3A4A5A6, 16'h1001, 1'b0, N, cyc_used);
            write_frame(2);
        join
        commit(32'hC0A80002, 48'hB1B2B3B4B5B6, 16'h2002);
        receive_frame("overlap_f2", 2, 32'hC0A80002, 48'hB1B2B3B4B5B6, 16'h2002, 1'b0, N, cyc_used);
        chk("overlap/drop", 64'(DROP_COUNT), 64'd0);

        // Drop: second commit while the first frame is still held.
        OUT_READY = 1'b0;
        write_frame(3);
        commit(32'h0B000001, 48'h0000000000D1, 16'h0D01);
        write_frame(4);
        commit(32'h0B000002, 48'h0000000000D2, 16'h0D02);
        chk("drop/count", 64'(DROP_COUNT), 64'd1);
        chk("drop/held_valid", 64'(OUT_VALID), 64'd1);
        chk("drop/held_byte0", 64'(OUT_DATA), 64'h03);
        chk("drop/held_ip", 64'(OUT_SRC_IP), 64'h0B000001);
        receive_frame("drop_f1", 3, 32'h0B000001, 48'h0000000000D1, 16'h0D01, 1'b0, N, cyc_used);
        write_frame(5);
        commit(32'h0B000003, 48'h0000000000D3, 16'h0D03);
        receive_frame("drop_f3", 5, 32'h0B000003, 48'h0000000000D3, 16'h0D03, 1'b0, N, cyc_used);
        chk("drop/count_after", 64'(DROP_COUNT), 64'd1);

        // Backpressure: ready one cycle in three.
        write_frame(6);
        commit(32'h0C000006, 48'h0000000000E6, 16'h0E06);
        receive_frame("bp", 6, 32'h0C000006, 48'h0000000000E6, 16'h0E06, 1'b1, N, cyc_used);

        // Commit in the same cycle as the final handshake of the streaming bank.
        write_frame(9);
        commit(32'h0D000009, 48'h0000000000F9, 16'h0F09);
        wait_cnt = 0;
        fork
            receive_frame("simul_f1", 9, 32'h0D000009, 48'h0000000000F9, 16'h0F09, 1'b0, N, cyc_used);
            begin
                write_frame(10);
                while (!(OUT_VALID === 1'b1 && OUT_LAST === 1'b1) && wait_cnt < 2000) begin
                    step();
                    wait_cnt++;
                end
                commit(32'h0D00000A, 48'h0000000000FA, 16'h0F0A);
            end
        join
        chk("simul/last_seen", 64'(wait_cnt < 2000), 64'd1);
        chk("simul/drop", 64'(DROP_COUNT), 64'd1);
        receive_frame("simul_f2", 10, 32'h0D00000A, 48'h0000000000FA, 16'h0F0A, 1'b0, N, cyc_used);

        // Reset while byte 300 is presented.
        write_frame(11);
        commit(32'h0E00000B, 48'h00000000000B, 16'h000B);
        receive_frame("rst_f1", 11, 32'h0E00000B, 48'h00000000000B, 16'h000B, 1'b0, 300, cyc_used);
        chk("rst/byte300_valid", 64'(OUT_VALID), 64'd1);
        chk("rst/byte300", 64'(OUT_DATA), 64'h37);
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        chk("rst/valid", 64'(OUT_VALID), 64'd0);
        chk("rst/last", 64'(OUT_LAST), 64'd0);
        chk("rst/drop", 64'(DROP_COUNT), 64'd0);
        chk("rst/data", 64'(OUT_DATA), 64'd0);
        repeat (5) step();
        chk("rst/reader_idle", 64'(OUT_VALID), 64'd0);
        write_frame(12);
        RX_EN = 1'b1; RX_ADDR = 10'd800; RX_DATA = 8'hEE;
        step();
        RX_EN = 1'b0;
        commit(32'h0E00000C, 48'h00000000000C, 16'h000C);
        receive_frame("rst_f2", 12, 32'h0E00000C, 48'h00000000000C, 16'h000C, 1'b0, N, cyc_used);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_buffer.md
# rx_frame_buffer

Double-banked frame store directly downstream of the UDP receive parser. It captures the parser's per-byte user-data writes into a write bank, commits the bank when the parser pulses frame-ready, and latches the sender's IP/MAC/UDP identity with that frame. It then streams the committed frame to the inference accelerator over an AXI-Stream-style byte interface. The next frame can be received while the previous one is streaming out.

## Interface
Parameters:
- USER_DATA_BYTES, 785, bytes per frame: 1 metadata byte plus 784 pixels.
- ADDR_WIDTH, 10, width of the byte address; 2**ADDR_WIDTH ≥ USER_DATA_BYTES.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- RX_DATA  in  8  byte from the parser.
- RX_ADDR  in  ADDR_WIDTH  byte index within the frame, 0-based.
- RX_EN  in  1  write strobe; one byte per cycle.
- FRAME_READY  in  1  single-cycle pulse: the frame just written is complete and valid.
- SRC_IP_ADDRESS  in  32  sender IP; valid during FRAME_READY.
- SRC_MAC_ADDRESS  in  48  sender MAC; valid during FRAME_READY.
- SRC_UDP_PORT  in  16  sender UDP port; valid during FRAME_READY.
- OUT_DATA  out  8  streamed frame byte.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  accelerator accepts the byte.
- OUT_LAST  out  1  asserted with byte USER_DATA_BYTES-1.
- OUT_SRC_IP  out  32  sideband for the frame being streamed; stable from first OUT_VALID through the last handshake.
- OUT_SRC_MAC  out  48  as OUT_SRC_IP.
- OUT_SRC_UDP  out  16  as OUT_SRC_IP.
- DROP_COUNT  out  16  number of frames dropped for lack of a free bank; saturates at 16'hFFFF.
- BANKS_BUSY  out  1  high when neither bank is FREE or being written; debug only.

## Operation
- Two banks, A and B. Each is a USER_DATA_BYTES × 8 RAM with a synchronous read. Each bank is in one of three states:
  - FREE: being written or available.
  - FULL: committed, waiting to be streamed.
  - READING: being streamed.
- wr_sel selects the write bank, which is always FREE. RX_EN writes RX_DATA to wr_sel[RX_ADDR].
  - Writes with RX_ADDR ≥ USER_DATA_BYTES are ignored.
  - Aborted packets (writes without FRAME_READY) leave the bank FREE; the next frame overwrites them.
- On FRAME_READY:
  - If the other bank is FREE: mark the write bank FULL, latch SRC_IP/MAC/UDP into that bank's sideband registers, and toggle wr_sel.
  - Otherwise: drop the frame, increment DROP_COUNT (saturating), keep wr_sel unchanged, and leave the bank FREE.
- Simultaneous events: if FRAME_READY arrives in the same cycle as the final OUT handshake that frees the other bank, the commit succeeds. The freed state is visible combinationally to the commit decision.
- Reader state machine:
  - IDLE → PRIME when a bank is FULL. Mark that bank READING and issue read address 0.
  - PRIME → STREAM after one cycle. RAM data is loaded into the output register and OUT_VALID is set.
  - STREAM: on each OUT_VALID && OUT_READY, present the next byte. Reads are prefetched so the bank sustains 1 byte/cycle with OUT_READY held high.
  - On the handshake of byte USER_DATA_BYTES-1 (OUT_LAST=1), mark the bank FREE, deassert OUT_VALID, and go to IDLE.
- The read address counter wraps only by return to IDLE. It never exceeds USER_DATA_BYTES-1.
- Backpressure: while OUT_VALID && !OUT_READY, OUT_DATA, OUT_LAST and the sideband outputs hold stable.
- Reset outputs: both banks FREE, wr_sel=A, reader IDLE, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, sideband outputs 0, DROP_COUNT=0, BANKS_BUSY=0.
- Reset mid-stream aborts the frame with no OUT_LAST. RAM contents are not cleared.

## Timing
- FRAME_READY is sampled at edge T. The bank is FULL after T.
- Reader leaves IDLE at T+1 and issues the read. OUT_VALID=1 with byte 0 after edge T+2, i.e. 2 cycles of commit-to-first-byte latency.
- With OUT_READY=1, the frame completes in USER_DATA_BYTES cycles. OUT_VALID drops the cycle after the last handshake.
- The next FULL bank may start PRIME the cycle after IDLE is re-entered. This gives one idle bubble plus the prime cycle between frames.
- A write at RX_ADDR in cycle T is readable by the reader from T+1. The reader never reads the write bank.

## Test plan
- Single frame: write bytes k → value k mod 256 for k = 0..784, then pulse FRAME_READY with IP 0x0A000002, MAC 0x001122334455, port 0x1234, and OUT_READY=1. Expect OUT_VALID 2 cycles later and 785 bytes 0,1,…,0x10 in order. OUT_LAST only on byte 784. Sideband equals the latched values.
- Overlap: commit frame 1, then write frame 2 while frame 1 streams. Commit frame 2 after frame 1's last handshake. Frame 2 streams next with its own sideband; DROP_COUNT=0.
- Drop: commit frame 1 with OUT_READY=0, then commit frame 2. Expect DROP_COUNT=1, and frame 1 still intact once OUT_READY=1. A third frame after frame 1 completes is accepted.
- Backpressure: toggle OUT_READY in a 1-of-3 pattern. Expect output data unchanged during stalls, no lost or duplicated bytes, and exactly 785 handshakes.
- Simultaneous events: FRAME_READY in the same cycle as frame 1's OUT_LAST handshake. Expect the commit to succeed and DROP_COUNT unchanged.
- Reset mid-stream at byte 300: expect OUT_VALID=0 the next cycle, DROP_COUNT=0, and the reader IDLE. A fresh frame afterwards streams correctly. A write with RX_ADDR=800 does not corrupt any byte.
